// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid / framing-error pulses.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote around every sample point.
module uart_rx #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned BAUD_TICK = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_TICK = BAUD_TICK / 2;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned BIT_W     = 3;
    localparam int unsigned DATA_W    = 8;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICK - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_TICK - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;

    logic                rx_s;
    logic [CNT_W-1:0]    last_cnt;
    logic                at_sample;
    logic                sample_bit;

    assign rx_s      = sync_q[1];
    assign last_cnt  = (state_q == S_START) ? HALF_LAST : BAUD_LAST;
    assign at_sample = (cnt_q == last_cnt);

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q, vote_d;

    // Capture the two samples preceding the decision point.
    always_comb begin
        vote_d = vote_q;
        if (cnt_q == last_cnt - CNT_W'(2)) vote_d[0] = rx_s;
        if (cnt_q == last_cnt - CNT_W'(1)) vote_d[1] = rx_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign sample_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    assign sample_bit = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (at_sample) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sample_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (at_sample) begin
                    cnt_d   = '0;
                    shift_d = {sample_bit, shift_q[DATA_W-1:1]};
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (at_sample) begin
                    cnt_d = '0;
                    if (sample_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            // Hold here until the line releases so a stuck-low line is not decoded as 0x00 frames.
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected pulses, a monitor pops and compares.
module tb_uart_rx;
    localparam int unsigned CLK_F    = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned BIT_CLKS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    uart_rx #(
        .CLOCK_FREQ(CLK_F),
        .BAUD_RATE (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    // All line drivers start and end on a falling edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid || frame_err) begin
            check("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse actual valid=%0b err=%0b data=%0h required=no pulse at %0t",
                         rx_valid, frame_err, rx_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 32'(frame_err), 32'(e.is_err));
                check("rx_data", 32'(rx_data), 32'(e.data));
                if (rx_valid) check("busy_after_valid", 32'(busy), 32'd0);
            end
        end
        prev_pulse = rx_valid | frame_err;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int wait_cnt;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single good frame
        push(1'b0, 8'h55);
        send_frame(8'h55, 1'b1);
        idle_bits(2);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Back-to-back frames with no idle gap
        push(1'b0, 8'hA3);
        push(1'b0, 8'h0F);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle_bits(2);

        // Short low glitch rejected by START
        busy_cnt = 0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("t3_busy_len_ok", 32'(busy_cnt >= 1 && busy_cnt <= 8), 32'd1);
        check("t3_busy_end", 32'(busy), 32'd0);
        check("t3_rx_data_hold", 32'(rx_data), 32'h0F);

        // Framing error, held-low line, then recovery
        push(1'b1, 8'h0F);
        send_frame(8'h81, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_busy_in_break", 32'(busy), 32'd1);
        rx = 1'b1;
        idle_bits(2);
        check("t4_rx_data_hold", 32'(rx_data), 32'h0F);
        push(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1);
        idle_bits(2);

        // Reset during data bit 4 of 0xF0
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_rx_data", 32'(rx_data), 32'h00);
        check("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("t5_rst_frame_err", 32'(frame_err), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        push(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1);
        idle_bits(2);

        // One-clock high glitch exactly at the bit-3 sample point
`ifdef UART_RX_MAJORITY_EN
        push(1'b0, 8'h00);
`else
        push(1'b0, 8'h08);
`endif
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        idle_bits(2);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Mirror of the team's uart_tx on the same Nexys A7 design.
- Takes the asynchronous serial line (board RX pin, or the uart_tx output in loopback) and rebuilds bytes by sampling at mid-bit.
- Delivers each byte as a one-cycle valid pulse to downstream logic such as a command parser or echo path. Also flags framing errors.

Parameters:
- CLOCK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line baud rate.
- Derived localparam BAUD_TICK = CLOCK_FREQ/BAUD_RATE: clocks per bit (10416 at defaults).
- Derived localparam HALF_TICK = BAUD_TICK/2: clocks to mid-bit (5208 at defaults).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line, asynchronous, idle high.
- rx_data  output  8  last correctly framed byte, LSB received first.
- rx_valid  output  1  one-cycle pulse: rx_data has been updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Synchronizer:
  - rx passes through 2 flip-flops; the output is rx_s.
  - Both flops reset to 1. All decisions use rx_s only.
- Counters:
  - 16-bit baud counter, 3-bit bit index, 8-bit shift register.
  - Counter returns to 0 on every state change.
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, busy=0.
  - State IDLE, counter 0, bit index 0.
  - Reset mid-frame abandons the frame with no output pulse.
- IDLE:
  - When rx_s==0, go to START.
- START:
  - Count up. At counter==HALF_TICK-1, sample.
  - Sample 0: go to DATA, bit index 0.
  - Sample 1: treat as glitch, return to IDLE, no pulse.
- DATA:
  - Count up. At counter==BAUD_TICK-1 (mid-bit), shift the sample into bit 7 and shift right, so the byte is LSB first.
  - Counter then goes to 0.
  - After bit index 7, go to STOP; otherwise increment the bit index.
- STOP:
  - At counter==BAUD_TICK-1, sample.
  - Sample 1: rx_data<=shift register, rx_valid=1 for exactly the next cycle, go to IDLE.
  - Sample 0: frame_err=1 for exactly the next cycle, rx_data unchanged, go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE.
  - This prevents a held-low line from being decoded as endless 0x00 frames.
- Timing:
  - Return to IDLE happens at mid-stop-bit, so back-to-back frames with zero idle gap are received.
  - Latency from the stop-bit centre to the rx_valid pulse is 1 clock. Add the 2-clock synchronizer delay relative to the pin.
- Pulse exclusivity: rx_valid and frame_err are never high in the same cycle, and each pulse lasts exactly 1 clock.
- State encoding: 3 bits. Illegal states go to IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point uses a 2-of-3 majority vote instead of one sample.
  - The three rx_s samples are taken at counter values N-2, N-1 and N, where N is HALF_TICK-1 for START and BAUD_TICK-1 for DATA/STOP.
  - The decision is still made at counter N, so all timing and latency are unchanged.
  - A one-clock glitch at the sample point is rejected.
- Undefined: a single sample is taken at counter N, and no vote registers are built.

Test Plan (sim params CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so BAUD_TICK=10, HALF_TICK=5; bench drives 10 clk/bit):
1. Frame 0x55 with a good stop bit -> one rx_valid pulse, rx_data=0x55, frame_err never high, busy falls after the pulse.
2. Frames 0xA3 then 0x0F, second start bit immediately after the first stop bit -> two rx_valid pulses, rx_data 0xA3 then 0x0F.
3. rx low for 3 clocks on an idle line -> START rejects it, no rx_valid/frame_err, busy high for at most 8 clocks then 0.
4. Frame 0x81 with stop bit 0, line held low 40 clocks then high, then frame 0x3C:
   - one frame_err pulse, no rx_valid, rx_data holds its prior value;
   - no further pulses while the line is low;
   - 0x3C is then received correctly.
5. rst asserted during data bit 4 of 0xF0 -> all outputs 0 immediately; after release, frame 0x3C gives rx_data=0x3C.
6. Frame 0x00 with rx forced high for 1 clock exactly at the bit-3 sample point:
   - with UART_RX_MAJORITY_EN: rx_data=0x00;
   - without: rx_data=0x08.
